cpu_dbg_ctrl: RTL and testbench
===============================

CPU_DBG_CTRL -- requirements
Module: cpu_dbg_ctrl

Interface
REQ-001 Parameter AWIDTH, default 8, SHALL set the program-address width, matching the PC/ROM address width.
REQ-002 Parameter CWIDTH, default 16, SHALL set the executed-cycle counter width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  controller can accept a command this cycle.
REQ-007 CMD  input  3  opcode: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 RESET_CPU, 7 reserved.
REQ-008 CMD_ARG  input  AWIDTH  step count (STEP) or breakpoint address (SET_BP).
REQ-009 PC_IN  input  AWIDTH  current PC value (ROM address) of the controlled CPU.
REQ-010 CPU_EN  output  1  CPU clock-enable; the CPU state advances only in cycles where it is 1.
REQ-011 CPU_RST  output  1  active-high reset to the PC and CPU state.
REQ-012 HALTED  output  1  state is HALTED.
REQ-013 BP_HIT  output  1  sticky flag: the last run stopped on the breakpoint.
REQ-014 CYCLE_CNT  output  CWIDTH  count of cycles with CPU_EN=1.

Function
REQ-015 FSM states SHALL be CPURST, HALTED, RUNNING and STEPPING.
REQ-016 A command SHALL be accepted on a rising edge where CMD_VALID=1 and CMD_READY=1, and its effect SHALL be visible from the next cycle.
REQ-017 CMD_READY SHALL be 1 in HALTED and RUNNING and 0 in CPURST and STEPPING.
REQ-018 CPURST SHALL last exactly 2 cycles with CPU_RST=1 and CPU_EN=0, then go to HALTED.
REQ-019 HALTED SHALL hold CPU_EN=0 and CPU_RST=0.
REQ-020 RUN in HALTED SHALL go to RUNNING and clear BP_HIT; RUN in RUNNING SHALL be ignored.
REQ-021 HALT in RUNNING SHALL go to HALTED; HALT in HALTED SHALL be ignored.
REQ-022 STEP in HALTED SHALL load the step counter with CMD_ARG (0 treated as 1), clear BP_HIT and go to STEPPING; STEP in RUNNING SHALL be ignored.
REQ-023 STEPPING SHALL hold CPU_EN=1 for exactly N cycles, decrementing the counter each cycle, then go to HALTED; breakpoints SHALL be ignored while stepping.
REQ-024 SET_BP SHALL store CMD_ARG as the breakpoint address and arm it; CLR_BP SHALL disarm it; both SHALL be accepted in HALTED or RUNNING without a state change.
REQ-025 RESET_CPU SHALL go to CPURST from HALTED or RUNNING, clear CYCLE_CNT and BP_HIT, and retain the breakpoint.
REQ-026 NOP and reserved opcodes SHALL be accepted and have no effect.
REQ-027 In RUNNING, CPU_EN SHALL be 1 except in a cycle where the breakpoint is armed, PC_IN equals the breakpoint address, and this is not the first RUNNING cycle after RUN.
REQ-028 The exception in REQ-027 SHALL use a combinational compare so the instruction at the breakpoint address is not executed.
REQ-029 In that breakpoint cycle the FSM SHALL go to HALTED at the next edge and set BP_HIT.
REQ-030 The first-cycle exemption SHALL let RUN resume from a breakpoint address.
REQ-031 If HALT is accepted in the same cycle a breakpoint match occurs, the FSM SHALL go to HALTED and BP_HIT SHALL be set.
REQ-032 CYCLE_CNT SHALL increment on each edge where CPU_EN=1 and SHALL saturate at all-ones.
REQ-033 CPU_EN SHALL never be 1 while CPU_RST is 1.

Reset
REQ-034 On an edge with RST=0: state=CPURST, cycle counter=0, CPU_RST=1, CPU_EN=0, HALTED=0, BP_HIT=0, CYCLE_CNT=0, CMD_READY=0, breakpoint disarmed, address=0, step counter=0.
REQ-035 Reset SHALL override any command or operation in progress, including mid-STEPPING.
REQ-036 The 2-cycle CPURST sequence SHALL start from the first edge with RST=1.

Verification
REQ-037 Release RST -> CPU_RST=1 for 2 cycles, then HALTED=1, CMD_READY=1, CPU_EN=0, CYCLE_CNT=0.
REQ-038 HALTED, STEP arg=3 -> CPU_EN=1 for exactly 3 cycles, CMD_READY=0 meanwhile, then HALTED, CYCLE_CNT=3; repeat with STEP arg=0 -> exactly 1 cycle.
REQ-039 SET_BP 0x05, RUN, PC_IN counting 0,1,2,... -> CPU_EN=0 in the cycle PC_IN=0x05, HALTED next cycle, BP_HIT=1, CYCLE_CNT=5.
REQ-040 From the REQ-039 end state, issue RUN with PC_IN=0x05 -> CPU_EN=1 in the first cycle, BP_HIT=0, no immediate re-halt.
REQ-041 RUNNING, CMD_VALID with HALT held -> CPU_EN=0 from the cycle after acceptance; repeat with RESET_CPU -> 2-cycle CPU_RST, CYCLE_CNT=0, breakpoint still armed.
REQ-042 RST=0 for one edge mid-STEPPING (arg=200) -> the REQ-034 values next cycle; force CYCLE_CNT near all-ones and run -> it holds at 0xFFFF.

Source files
------------

// File: rtl/cpu_dbg_ctrl.sv
// Debug controller for a small CPU: reset sequencing, run/halt/single-step
// control, a single address breakpoint and an executed-cycle counter.
module cpu_dbg_ctrl #(
    parameter int AWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [2:0]        CMD,
    input  logic [AWIDTH-1:0] CMD_ARG,
    input  logic [AWIDTH-1:0] PC_IN,
    output logic              CPU_EN,
    output logic              CPU_RST,
    output logic              HALTED,
    output logic              BP_HIT,
    output logic [CWIDTH-1:0] CYCLE_CNT
);

    localparam logic [2:0] OP_RUN       = 3'd1;
    localparam logic [2:0] OP_HALT      = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_SET_BP    = 3'd4;
    localparam logic [2:0] OP_CLR_BP    = 3'd5;
    localparam logic [2:0] OP_RESET_CPU = 3'd6;

    localparam logic [AWIDTH-1:0] ONE_A = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] ONE_C = {{(CWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_CPURST,
        ST_HALTED,
        ST_RUNNING,
        ST_STEPPING
    } state_t;

    state_t            state_reg, state_next;
    logic              rst_cnt_reg, rst_cnt_next;
    logic              first_run_reg, first_run_next;
    logic              bp_armed_reg, bp_armed_next;
    logic [AWIDTH-1:0] bp_addr_reg, bp_addr_next;
    logic [AWIDTH-1:0] step_cnt_reg, step_cnt_next;
    logic              bp_hit_reg, bp_hit_next;
    logic [CWIDTH-1:0] cycle_cnt_reg;
    logic              cycle_clr;
    logic              cmd_accept;
    logic              bp_stop;

    // Control state registers; reset overrides everything, including stepping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= ST_CPURST;
            rst_cnt_reg   <= 1'b0;
            first_run_reg <= 1'b0;
            bp_armed_reg  <= 1'b0;
            bp_addr_reg   <= '0;
            step_cnt_reg  <= '0;
            bp_hit_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            first_run_reg <= first_run_next;
            bp_armed_reg  <= bp_armed_next;
            bp_addr_reg   <= bp_addr_next;
            step_cnt_reg  <= step_cnt_next;
            bp_hit_reg    <= bp_hit_next;
        end
    end

    // Saturating count of cycles in which the CPU actually advanced.
    always_ff @(posedge CLK) begin
        if (!RST || cycle_clr) begin
            cycle_cnt_reg <= '0;
        end else if (CPU_EN && !(&cycle_cnt_reg)) begin
            cycle_cnt_reg <= cycle_cnt_reg + ONE_C;
        end
    end

    // Outputs decoded from state; the breakpoint compare is combinational so
    // the CPU is frozen in the very cycle its PC reaches the breakpoint.
    always_comb begin
        CMD_READY  = (state_reg == ST_HALTED) || (state_reg == ST_RUNNING);
        CPU_RST    = (state_reg == ST_CPURST);
        HALTED     = (state_reg == ST_HALTED);
        cmd_accept = CMD_VALID && CMD_READY;
        bp_stop    = (state_reg == ST_RUNNING) && bp_armed_reg &&
                     (PC_IN == bp_addr_reg) && !first_run_reg;
        CPU_EN     = ((state_reg == ST_RUNNING) && !bp_stop) ||
                     (state_reg == ST_STEPPING);
        BP_HIT     = bp_hit_reg;
        CYCLE_CNT  = cycle_cnt_reg;
    end

    // Next-state logic: command decode, breakpoint stop and step countdown.
    always_comb begin
        state_next     = state_reg;
        rst_cnt_next   = rst_cnt_reg;
        first_run_next = 1'b0;
        bp_armed_next  = bp_armed_reg;
        bp_addr_next   = bp_addr_reg;
        step_cnt_next  = step_cnt_reg;
        bp_hit_next    = bp_hit_reg;
        cycle_clr      = 1'b0;

        case (state_reg)
            ST_CPURST: begin
                if (rst_cnt_reg) begin
                    rst_cnt_next = 1'b0;
                    state_next   = ST_HALTED;
                end else begin
                    rst_cnt_next = 1'b1;
                end
            end
            ST_HALTED: begin
                if (cmd_accept) begin
                    case (CMD)
                        OP_RUN: begin
                            state_next     = ST_RUNNING;
                            bp_hit_next    = 1'b0;
                            first_run_next = 1'b1;
                        end
                        OP_STEP: begin
                            step_cnt_next = (CMD_ARG == '0) ? ONE_A : CMD_ARG;
                            bp_hit_next   = 1'b0;
                            state_next    = ST_STEPPING;
                        end
                        OP_RESET_CPU: begin
                            state_next   = ST_CPURST;
                            rst_cnt_next = 1'b0;
                            bp_hit_next  = 1'b0;
                            cycle_clr    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUNNING: begin
                if (cmd_accept && (CMD == OP_RESET_CPU)) begin
                    state_next   = ST_CPURST;
                    rst_cnt_next = 1'b0;
                    bp_hit_next  = 1'b0;
                    cycle_clr    = 1'b1;
                end else if (bp_stop) begin
                    // A HALT arriving together with a match still records the hit.
                    state_next  = ST_HALTED;
                    bp_hit_next = 1'b1;
                end else if (cmd_accept && (CMD == OP_HALT)) begin
                    state_next = ST_HALTED;
                end
            end
            ST_STEPPING: begin
                step_cnt_next = step_cnt_reg - ONE_A;
                if (step_cnt_reg <= ONE_A) begin
                    state_next = ST_HALTED;
                end
            end
            default: state_next = ST_CPURST;
        endcase

        // Breakpoint edits never change state and apply wherever commands are accepted.
        if (cmd_accept && (CMD == OP_SET_BP)) begin
            bp_addr_next  = CMD_ARG;
            bp_armed_next = 1'b1;
        end else if (cmd_accept && (CMD == OP_CLR_BP)) begin
            bp_armed_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Scoreboard bench for cpu_dbg_ctrl: stimulus pushes the expected output
// snapshot for the current cycle, a monitor pops and compares on negedge.
module tb_cpu_dbg_ctrl;

    localparam int AW = 8;
    localparam int CW = 16;

    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3;
    localparam logic [2:0] SET_BP = 3'd4, CLR_BP = 3'd5, RESET_CPU = 3'd6, RSVD = 3'd7;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd;
    logic [AW-1:0] cmd_arg;
    logic [AW-1:0] pc_in;
    logic          cpu_en;
    logic          cpu_rst;
    logic          halted;
    logic          bp_hit;
    logic [CW-1:0] cycle_cnt;

    cpu_dbg_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD       (cmd),
        .CMD_ARG   (cmd_arg),
        .PC_IN     (pc_in),
        .CPU_EN    (cpu_en),
        .CPU_RST   (cpu_rst),
        .HALTED    (halted),
        .BP_HIT    (bp_hit),
        .CYCLE_CNT (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [20:0] vec;   // {ready, cpu_rst, cpu_en, halted, bp_hit, cycle_cnt}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string name, input logic rdy, input logic crst,
                              input logic en, input logic hlt, input logic bp,
                              input logic [15:0] cnt);
        exp_t e;
        e.name = name;
        e.vec  = {rdy, crst, en, hlt, bp, cnt};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] arg);
        cmd_valid = 1'b1;
        cmd       = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd       = NOP;
        cmd_arg   = '0;
    endtask

    // Watchdog: the run must finish well before this wait expires.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete, errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: compare every pending expectation against the live outputs.
    initial begin
        exp_t        e;
        logic [20:0] got;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {cmd_ready, cpu_rst, cpu_en, halted, bp_hit, cycle_cnt};
                checks++;
                if (got !== e.vec) begin
                    errors++;
                    $display("FAIL %s: got rdy=%b rst=%b en=%b hlt=%b bp=%b cnt=%h, want rdy=%b rst=%b en=%b hlt=%b bp=%b cnt=%h",
                             e.name, got[20], got[19], got[18], got[17], got[16], got[15:0],
                             e.vec[20], e.vec[19], e.vec[18], e.vec[17], e.vec[16], e.vec[15:0]);
                end else begin
                    $display("check %s ok cnt=%h", e.name, got[15:0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd       = NOP;
        cmd_arg   = '0;
        pc_in     = '0;

        // Reset and the two-cycle CPU reset sequence after release.
        tick();
        tick();
        checks++;
        if ((cpu_rst !== 1'b1) || (cpu_en !== 1'b0) || (halted !== 1'b0) ||
            (cmd_ready !== 1'b0) || (bp_hit !== 1'b0) || (cycle_cnt !== 16'd0)) begin
            errors++;
            $display("FAIL reset_direct: rdy=%b rst=%b en=%b hlt=%b bp=%b cnt=%h",
                     cmd_ready, cpu_rst, cpu_en, halted, bp_hit, cycle_cnt);
        end else begin
            $display("check reset_direct ok cnt=%h", cycle_cnt);
        end
        expect_out("reset_state", 0, 1, 0, 0, 0, 16'd0);
        rst = 1'b1;
        tick();
        expect_out("cpurst_2nd", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("halted_after_rst", 1, 0, 0, 1, 0, 16'd0);

        // Single-step three cycles, then STEP 0 counts as one.
        issue(STEP, 8'd3);
        expect_out("step3_c1", 0, 0, 1, 0, 0, 16'd0);
        tick();
        expect_out("step3_c2", 0, 0, 1, 0, 0, 16'd1);
        tick();
        expect_out("step3_c3", 0, 0, 1, 0, 0, 16'd2);
        tick();
        expect_out("step3_done", 1, 0, 0, 1, 0, 16'd3);
        issue(STEP, 8'd0);
        expect_out("step0_c1", 0, 0, 1, 0, 0, 16'd3);
        tick();
        expect_out("step0_done", 1, 0, 0, 1, 0, 16'd4);

        // NOP and reserved opcodes change nothing.
        issue(NOP, 8'd9);
        expect_out("nop", 1, 0, 0, 1, 0, 16'd4);
        issue(RSVD, 8'd9);
        expect_out("reserved", 1, 0, 0, 1, 0, 16'd4);

        // RESET_CPU from HALTED clears the counter.
        issue(RESET_CPU, 8'd0);
        expect_out("rstcpu_c1", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("rstcpu_c2", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("rstcpu_done", 1, 0, 0, 1, 0, 16'd0);

        // Breakpoint at 0x05 with PC counting up from 0.
        issue(SET_BP, 8'h05);
        expect_out("set_bp", 1, 0, 0, 1, 0, 16'd0);
        pc_in = 8'd0;
        issue(RUN, 8'd0);
        for (int k = 0; k <= 5; k++) begin
            pc_in = AW'(k);
            expect_out($sformatf("run_pc%0d", k), 1, 0, (k < 5) ? 1'b1 : 1'b0, 0, 0, 16'(k));
            tick();
        end
        expect_out("bp_halted", 1, 0, 0, 1, 1, 16'd5);

        // Resume from the breakpoint address without re-halting.
        issue(RUN, 8'd0);
        expect_out("resume_first", 1, 0, 1, 0, 0, 16'd5);
        tick();
        pc_in = 8'd6;
        expect_out("resume_pc6", 1, 0, 1, 0, 0, 16'd6);
        tick();
        pc_in = 8'd7;
        cmd_valid = 1'b1;
        cmd       = HALT;
        expect_out("halt_accept_cycle", 1, 0, 1, 0, 0, 16'd7);
        tick();
        expect_out("halt_done", 1, 0, 0, 1, 0, 16'd8);
        tick();
        expect_out("halt_held_ignored", 1, 0, 0, 1, 0, 16'd8);
        cmd_valid = 1'b0;
        cmd       = NOP;

        // RESET_CPU while running: counter cleared, breakpoint kept.
        pc_in = 8'd8;
        issue(RUN, 8'd0);
        expect_out("run_again", 1, 0, 1, 0, 0, 16'd8);
        cmd_valid = 1'b1;
        cmd       = RESET_CPU;
        tick();
        cmd_valid = 1'b0;
        cmd       = NOP;
        expect_out("rstrun_c1", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("rstrun_c2", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("rstrun_done", 1, 0, 0, 1, 0, 16'd0);
        pc_in = 8'd4;
        issue(RUN, 8'd0);
        expect_out("bp_kept_pc4", 1, 0, 1, 0, 0, 16'd0);
        tick();
        pc_in = 8'd5;
        expect_out("bp_kept_pc5", 1, 0, 0, 0, 0, 16'd1);
        tick();
        expect_out("bp_kept_halt", 1, 0, 0, 1, 1, 16'd1);

        // HALT accepted in the same cycle as a breakpoint match.
        pc_in = 8'd4;
        issue(RUN, 8'd0);
        expect_out("halt_bp_pc4", 1, 0, 1, 0, 0, 16'd1);
        tick();
        pc_in     = 8'd5;
        cmd_valid = 1'b1;
        cmd       = HALT;
        expect_out("halt_bp_same", 1, 0, 0, 0, 0, 16'd2);
        tick();
        cmd_valid = 1'b0;
        cmd       = NOP;
        expect_out("halt_bp_done", 1, 0, 0, 1, 1, 16'd2);

        // CLR_BP disarms: PC passes 0x05 freely.
        issue(CLR_BP, 8'd0);
        expect_out("clr_bp", 1, 0, 0, 1, 1, 16'd2);
        pc_in = 8'd4;
        issue(RUN, 8'd0);
        expect_out("clr_run_pc4", 1, 0, 1, 0, 0, 16'd2);
        tick();
        pc_in = 8'd5;
        expect_out("clr_run_pc5", 1, 0, 1, 0, 0, 16'd3);
        tick();
        pc_in = 8'd6;
        expect_out("clr_run_pc6", 1, 0, 1, 0, 0, 16'd4);
        issue(HALT, 8'd0);
        expect_out("clr_halt", 1, 0, 0, 1, 0, 16'd5);

        // Reset pulse in the middle of a long step.
        issue(STEP, 8'd200);
        expect_out("step200_c1", 0, 0, 1, 0, 0, 16'd5);
        tick();
        expect_out("step200_c2", 0, 0, 1, 0, 0, 16'd6);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expect_out("midstep_reset", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("midstep_cpurst2", 0, 1, 0, 0, 0, 16'd0);
        tick();
        expect_out("midstep_halted", 1, 0, 0, 1, 0, 16'd0);

        // Counter saturation during a long free run (breakpoint disarmed by reset).
        pc_in = 8'd0;
        issue(RUN, 8'd0);
        for (int i = 0; i < 65540; i++) begin
            if (i >= 65533) begin
                expect_out($sformatf("sat_%0d", i), 1, 0, 1, 0, 0,
                           (i >= 65535) ? 16'hFFFF : 16'(i));
            end
            tick();
        end
        issue(HALT, 8'd0);
        expect_out("sat_halted", 1, 0, 0, 1, 0, 16'hFFFF);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
